// File: rtl/fetch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pc_unit : PC register, next-PC resolution and return stack   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module fetch_pc_unit #(
  parameter int PC_WIDTH  = 10,
  parameter int OP_WIDTH  = 5,
  parameter int RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        halt,
  input  logic [OP_WIDTH-1:0]         opcode,
  input  logic                        jump,
  input  logic                        call,
  input  logic                        ret,
  input  logic [PC_WIDTH-1:0]         target,
  input  logic                        eq_flag,
  input  logic                        zero_flag,
  input  logic                        gt_flag,
  input  logic                        lt_flag,
  output logic [PC_WIDTH-1:0]         pc,
  output logic                        running,
  output logic                        done,
  output logic                        fault,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  localparam int c_ras_aw = $clog2(RAS_DEPTH);
  localparam int c_cnt_w  = c_ras_aw + 1;

  localparam logic [c_cnt_w-1:0] c_ras_full = c_cnt_w'(RAS_DEPTH);
  localparam logic [c_cnt_w-1:0] c_ras_zero = '0;

  localparam logic [OP_WIDTH-1:0] c_op_je  = OP_WIDTH'(5'b00011);
  localparam logic [OP_WIDTH-1:0] c_op_jz  = OP_WIDTH'(5'b00100);
  localparam logic [OP_WIDTH-1:0] c_op_jgt = OP_WIDTH'(5'b11001);
  localparam logic [OP_WIDTH-1:0] c_op_jlt = OP_WIDTH'(5'b11010);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_run    = 2'd1;
  localparam logic [1:0] c_st_halted = 2'd2;
  localparam logic [1:0] c_st_fault  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [c_cnt_w-1:0]  r_ras_cnt;
  logic [c_cnt_w-1:0]  w_ras_cnt_nxt;
  logic [c_ras_aw-1:0] w_wr_idx;
  logic [c_ras_aw-1:0] w_rd_idx;
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic                w_push;
  logic                w_taken;

  // Natural wrap of the PC width gives the modulo-2^PC_WIDTH increment.
  assign w_pc_inc = r_pc + PC_WIDTH'(1);
  assign w_wr_idx = r_ras_cnt[c_ras_aw-1:0];
  assign w_rd_idx = r_ras_cnt[c_ras_aw-1:0] - c_ras_aw'(1);

  always_comb begin
    case (opcode)
      c_op_je:  w_taken = eq_flag;
      c_op_jz:  w_taken = zero_flag;
      c_op_jgt: w_taken = gt_flag;
      c_op_jlt: w_taken = lt_flag;
      default:  w_taken = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_pc      <= '0;
      r_ras_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ras_cnt <= w_ras_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ras_cnt_nxt = r_ras_cnt;
    w_push        = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_state_nxt = c_st_run;
          w_pc_nxt    = '0;
        end
      end
      c_st_run: begin
        // Priority: halt, illegal call+ret, underflow, overflow, call, ret, jump.
        if (halt) begin
          w_state_nxt = c_st_halted;
        end else if (call && ret) begin
          w_state_nxt = c_st_fault;
        end else if (ret && (r_ras_cnt == c_ras_zero)) begin
          w_state_nxt = c_st_fault;
        end else if (call && (r_ras_cnt == c_ras_full)) begin
          w_state_nxt = c_st_fault;
        end else if (call) begin
          w_push        = 1'b1;
          w_ras_cnt_nxt = r_ras_cnt + c_cnt_w'(1);
          w_pc_nxt      = target;
        end else if (ret) begin
          w_ras_cnt_nxt = r_ras_cnt - c_cnt_w'(1);
          w_pc_nxt      = r_ras[w_rd_idx];
        end else if (jump && w_taken) begin
          w_pc_nxt = target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      c_st_halted: begin
        if (start) begin
          w_state_nxt   = c_st_run;
          w_pc_nxt      = '0;
          w_ras_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = c_st_fault;
      end
    endcase
  end

  always_comb begin
    running = (r_state == c_st_run);
    done    = (r_state == c_st_halted);
    fault   = (r_state == c_st_fault);
  end

  for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ras[gi] <= '0;
      end else if (w_push && (w_wr_idx == c_ras_aw'(gi))) begin
        r_ras[gi] <= w_pc_inc;
      end
    end
  end

  assign pc        = r_pc;
  assign ras_count = r_ras_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_pc_unit : vector table, corner sequences, random vs model |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_fetch_pc_unit;

  localparam int PCW   = 10;
  localparam int OPW   = 5;
  localparam int DEPTH = 4;
  localparam int CNTW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            halt = 1'b0;
  logic [OPW-1:0]  opcode = '0;
  logic            jump = 1'b0;
  logic            call = 1'b0;
  logic            ret = 1'b0;
  logic [PCW-1:0]  target = '0;
  logic            eq_flag = 1'b0;
  logic            zero_flag = 1'b0;
  logic            gt_flag = 1'b0;
  logic            lt_flag = 1'b0;
  logic [PCW-1:0]  pc;
  logic            running;
  logic            done;
  logic            fault;
  logic [CNTW-1:0] ras_count;

  fetch_pc_unit #(.PC_WIDTH(PCW), .OP_WIDTH(OPW), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .opcode(opcode),
    .jump(jump), .call(call), .ret(ret), .target(target),
    .eq_flag(eq_flag), .zero_flag(zero_flag), .gt_flag(gt_flag), .lt_flag(lt_flag),
    .pc(pc), .running(running), .done(done), .fault(fault), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic           s, h;
    logic [OPW-1:0] op;
    logic           j, c, r;
    logic [PCW-1:0] tgt;
    logic [3:0]     f;      // eq, zero, gt, lt
    int             epc, ecnt;
    logic           erun, edone, efault;
  } vec_t;

  vec_t tbl[$];

  // Reference model: 0 idle, 1 run, 2 halted, 3 fault; stack as a queue.
  int m_state;
  int m_pc;
  int m_stk[$];

  function automatic vec_t mk(input logic s, h, input int op, input logic j, c, r,
                              input int tgt, input logic [3:0] f, input int epc, ecnt,
                              input logic erun, edone, efault);
    vec_t v;
    v.s = s; v.h = h; v.op = OPW'(op); v.j = j; v.c = c; v.r = r;
    v.tgt = PCW'(tgt); v.f = f; v.epc = epc; v.ecnt = ecnt;
    v.erun = erun; v.edone = edone; v.efault = efault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int epc, ecnt,
                           input logic erun, edone, efault);
    chk({tag, ".pc"}, 32'(pc), epc);
    chk({tag, ".ras_count"}, 32'(ras_count), ecnt);
    chk({tag, ".running"}, 32'(running), 32'(erun));
    chk({tag, ".done"}, 32'(done), 32'(edone));
    chk({tag, ".fault"}, 32'(fault), 32'(efault));
  endtask

  task automatic drive(input logic s, h, input int op, input logic j, c, r,
                       input int tgt, input logic [3:0] f);
    start = s; halt = h; opcode = OPW'(op); jump = j; call = c; ret = r;
    target = PCW'(tgt);
    eq_flag = f[3]; zero_flag = f[2]; gt_flag = f[1]; lt_flag = f[0];
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 4'b0000);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_stk.delete();
  endtask

  // Called at a negedge: asynchronous pulse, released before the next posedge.
  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  function automatic bit m_taken();
    case (int'(opcode))
      3:       return eq_flag;
      4:       return zero_flag;
      25:      return gt_flag;
      26:      return lt_flag;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step();
    int modv;
    modv = 1 << PCW;
    case (m_state)
      0: if (start) begin m_state = 1; m_pc = 0; end
      1: begin
        if (halt) m_state = 2;
        else if (call && ret) m_state = 3;
        else if (ret && m_stk.size() == 0) m_state = 3;
        else if (call && m_stk.size() == DEPTH) m_state = 3;
        else if (call) begin
          m_stk.push_back((m_pc + 1) % modv);
          m_pc = int'(target);
        end else if (ret) m_pc = m_stk.pop_back();
        else if (jump && m_taken()) m_pc = int'(target);
        else m_pc = (m_pc + 1) % modv;
      end
      2: if (start) begin m_stk.delete(); m_pc = 0; m_state = 1; end
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_pc, m_stk.size(), m_state == 1, m_state == 2, m_state == 3);
  endtask

  initial begin
    int op_pick[4];
    op_pick[0] = 3; op_pick[1] = 4; op_pick[2] = 25; op_pick[3] = 26;

    // ---------------- reset state ----------------
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all("idle", 0, 0, 0, 0, 0);

    // ---------------- vector table ----------------
    //           s  h  op j  c  r  tgt  flags     pc  cnt run dn flt
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   4'b0000, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   4'b0000, 1,   0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   4'b0000, 2,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   4'b0000, 3,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3, 1, 0, 0, 40,  4'b0111, 4,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 3, 1, 0, 0, 40,  4'b1000, 40,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4, 1, 0, 0, 60,  4'b1011, 41,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4, 1, 0, 0, 60,  4'b0100, 60,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 25, 1, 0, 0, 80, 4'b1101, 61,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 25, 1, 0, 0, 80, 4'b0010, 80,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 26, 1, 0, 0, 90, 4'b1110, 81,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 26, 1, 0, 0, 90, 4'b0001, 90,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 5,   4'b0000, 5,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 100, 4'b0000, 100, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   4'b0000, 101, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 200, 4'b0000, 200, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 300, 4'b0000, 102, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,   4'b0000, 6,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 7,   4'b0000, 7,   1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 9,   4'b0000, 7,   1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 55,  4'b0000, 7,   1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   4'b0000, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,   4'b0000, 0,   0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   4'b0000, 0,   0, 0, 0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].h, int'(tbl[i].op), tbl[i].j, tbl[i].c, tbl[i].r,
            int'(tbl[i].tgt), tbl[i].f);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].epc, tbl[i].ecnt,
                tbl[i].erun, tbl[i].edone, tbl[i].efault);
    end

    // ---------------- overflow: fifth call faults ----------------
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 4'b0000); tick();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 1, 0, 10 * k, 4'b0000); tick();
      check_all($sformatf("ovf.call%0d", k), 10 * k, k, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 1, 0, 50, 4'b0000); tick();
    check_all("ovf.call5", 40, 4, 0, 0, 1);
    idle_in(); tick();
    check_all("ovf.frozen", 40, 4, 0, 0, 1);

    // ---------------- underflow right after start ----------------
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 4'b0000); tick();
    drive(0, 0, 0, 0, 0, 1, 0, 4'b0000); tick();
    check_all("udf", 0, 0, 0, 0, 1);

    // ---------------- call and ret together ----------------
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 4'b0000); tick();
    idle_in(); tick();
    drive(0, 0, 0, 0, 1, 1, 33, 4'b0000); tick();
    check_all("callret", 1, 0, 0, 0, 1);

    // ---------------- wrap at top of address space ----------------
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 4'b0000); tick();
    drive(0, 0, 0, 1, 0, 0, 1023, 4'b0000); tick();
    check_all("wrap.jmp", 1023, 0, 1, 0, 0);
    idle_in(); tick();
    check_all("wrap.inc", 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 1023, 4'b0000); tick();
    drive(0, 0, 0, 0, 1, 0, 500, 4'b0000); tick();
    check_all("wrap.call", 500, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 4'b0000); tick();
    check_all("wrap.ret", 0, 0, 1, 0, 0);

    // ---------------- asynchronous reset mid-run ----------------
    idle_in(); tick(); tick();
    check_all("async.pre", 2, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all("async.low", 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    drive(0, 0, 0, 1, 1, 0, 77, 4'b1111); tick();
    check_all("idle.ignore", 0, 0, 0, 0, 0);

    // ---------------- randomized against the model ----------------
    do_reset();
    check_model("rnd.reset");
    for (int n = 0; n < 800; n++) begin
      if (m_state == 3 && ($urandom % 3) == 0) begin
        do_reset();
        check_model($sformatf("rnd%0d.reset", n));
      end
      start     = (m_state == 1) ? (($urandom % 8) == 0) : (($urandom % 3) == 0);
      halt      = (($urandom % 24) == 0);
      call      = (($urandom % 5) == 0);
      ret       = (($urandom % 5) == 0);
      jump      = (($urandom % 3) == 0);
      opcode    = (($urandom % 2) == 0) ? OPW'(op_pick[$urandom % 4]) : OPW'($urandom);
      target    = PCW'($urandom);
      eq_flag   = 1'($urandom);
      zero_flag = 1'($urandom);
      gt_flag   = 1'($urandom);
      lt_flag   = 1'($urandom);
      model_step();
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
